// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, per-bit edge counter, deserialiser, parity/stop check.
// Optional false-start rejection is enabled by defining UART_RX_START_CHECK_EN.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | line idle, edge counter held at 0, waiting for RX_IN low
// START  | start bit time (optionally aborted on a high sample)
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | parity bit, only when PAR_EN was set at frame start
// STOP   | stop bit; frame result is committed at its bit end
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    input  logic                  sampling_done,
    output logic [PRESC_W-1:0]    edge_cnt,
    output logic                  data_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0]     BIT_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0]     BIT_ONE  = BCW'(1);
    localparam logic [PRESC_W-1:0] EDGE_ONE = PRESC_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                r_state, w_next;
    logic [PRESC_W-1:0]    r_edge_cnt, r_presc;
    logic [BCW-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift, r_p_data;
    logic                  r_par_en, r_par_typ;
    logic                  r_par_err, r_stp_err, r_data_valid;
    logic                  w_bit_end, w_frame_start, w_frame_end;
    logic                  w_par_err_nxt, w_stp_err_nxt;

    assign w_bit_end     = (r_edge_cnt == (r_presc - EDGE_ONE));
    assign w_frame_start = (r_state == S_IDLE) && !RX_IN;
    assign w_frame_end   = (r_state == S_STOP) && w_bit_end;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_par_err_nxt = r_par_err;
        w_stp_err_nxt = r_stp_err;
        case (r_state)
            S_IDLE: begin
                if (!RX_IN) begin
                    w_next        = S_START;
                    w_par_err_nxt = 1'b0;
                    w_stp_err_nxt = 1'b0;
                end
            end
            S_START: begin
`ifdef UART_RX_START_CHECK_EN
                if (sampling_done && sampled_bit) w_next = S_IDLE;
                else if (w_bit_end)               w_next = S_DATA;
`else
                if (w_bit_end) w_next = S_DATA;
`endif
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == BIT_LAST))
                    w_next = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (sampling_done) w_par_err_nxt = sampled_bit ^ (^r_shift) ^ r_par_typ;
                if (w_bit_end)     w_next = S_STOP;
            end
            S_STOP: begin
                if (sampling_done) w_stp_err_nxt = ~sampled_bit;
                if (w_bit_end)     w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Error flags use their next values so a sample landing on the final edge still counts.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt   <= '0;
            r_presc      <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_p_data     <= '0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_par_err    <= w_par_err_nxt;
            r_stp_err    <= w_stp_err_nxt;
            r_data_valid <= w_frame_end && !w_par_err_nxt && !w_stp_err_nxt;
            if (w_frame_end && !w_par_err_nxt && !w_stp_err_nxt)
                r_p_data <= r_shift;
            if (w_frame_start) begin
                r_presc   <= Prescale;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
            end
            if (r_state == S_IDLE || w_next == S_IDLE || w_bit_end)
                r_edge_cnt <= '0;
            else
                r_edge_cnt <= r_edge_cnt + EDGE_ONE;
            if (r_state == S_START)
                r_bit_cnt <= '0;
            else if (r_state == S_DATA && w_bit_end)
                r_bit_cnt <= r_bit_cnt + BIT_ONE;
            if (r_state == S_DATA && sampling_done)
                r_shift <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
        end
    end

    assign edge_cnt     = r_edge_cnt;
    assign data_samp_en = (r_state != S_IDLE);
    assign P_DATA       = r_p_data;
    assign data_valid   = r_data_valid;
    assign par_err      = r_par_err;
    assign stp_err      = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames with an inline sampler model.
// Expected data/arrival cycle are queued at stimulus time; a monitor checks each data_valid pulse.
`timescale 1ns/1ps

module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [4:0] Prescale = 5'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit = 1'b0;
    logic       sampling_done = 1'b0;
    logic [4:0] edge_cnt;
    logic       data_samp_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(5)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
        .sampling_done(sampling_done), .edge_cnt(edge_cnt), .data_samp_en(data_samp_en),
        .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST && data_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pulse with P_DATA=0x%0h expected none (cycle %0d)", P_DATA, cyc);
            end else begin
                e = q.pop_front();
                chk("p_data", 32'(P_DATA), 32'(e.data));
                chk("valid_cycle", 32'(cyc), 32'(e.at));
                chk("flags_at_valid", 32'({par_err, stp_err}), 32'(0));
            end
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        sampling_done = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_edge_cnt"}, 32'(edge_cnt), 32'(0));
        chk({tag, "_samp_en"}, 32'(data_samp_en), 32'(0));
        chk({tag, "_p_data"}, 32'(P_DATA), 32'(0));
        chk({tag, "_valid"}, 32'(data_valid), 32'(0));
        chk({tag, "_errs"}, 32'({par_err, stp_err}), 32'(0));
    endtask

    // Drives one frame from a negedge; sampler reports the line value mid-bit.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pt,
                              input logic par_bit, input logic stop_bit, input bit ok, input int rst_at);
        logic [10:0] bits;
        int nb;
        bits = '0;
        bits[8:1] = d;
        if (pe) begin
            bits[9] = par_bit;
            bits[10] = stop_bit;
            nb = 11;
        end else begin
            bits[9] = stop_bit;
            nb = 10;
        end
        Prescale = 5'(p);
        PAR_EN = pe;
        PAR_TYP = pt;
        if (ok) q.push_back('{data: d, at: cyc + 1 + nb * p});
        for (int g = 0; g < nb * p; g++) begin
            if (g >= 1) begin
                chk("edge_cnt", 32'(edge_cnt), 32'((g - 1) % p));
                chk("samp_en", 32'(data_samp_en), 32'(1));
            end
            if (g == 2) chk("errs_cleared_at_start", 32'({par_err, stp_err}), 32'(0));
            if (g == rst_at) begin
                RST = 1'b0;
                RX_IN = 1'b1;
                sampling_done = 1'b0;
                #1;
                check_reset_outputs("midframe_rst");
                @(negedge CLK);
                RST = 1'b1;
                return;
            end
            if (g == 1) begin
                Prescale = 5'd6;
                PAR_EN = ~pe;
                PAR_TYP = ~pt;
            end
            RX_IN = bits[g / p];
            sampled_bit = bits[g / p];
            sampling_done = ((g % p) == p / 2);
            @(negedge CLK);
        end
        RX_IN = 1'b1;
        sampling_done = 1'b0;
    endtask

    // Two-cycle low glitch followed by an idle-high line, with the sampler still pulsing.
    task automatic glitch(input int p);
        Prescale = 5'(p);
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
`ifndef UART_RX_START_CHECK_EN
        q.push_back('{data: 8'hFF, at: cyc + 1 + 10 * p});
`endif
        for (int g = 0; g < 10 * p; g++) begin
            RX_IN = (g >= 2);
            sampled_bit = (g >= 2);
            sampling_done = ((g % p) == p / 2);
            @(negedge CLK);
        end
        RX_IN = 1'b1;
        sampling_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b1;
        idle(3);

        // 8 clocks per bit, even parity, good frame: 88 cycles
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(3);
        // 16 clocks per bit, no parity: 160 cycles
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(3);
        // odd parity with parity bit 0 on four ones -> parity error
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        idle(3);
        chk("par_err_set", 32'(par_err), 32'(1));
        chk("stp_err_after_par", 32'(stp_err), 32'(0));
        chk("p_data_held_par", 32'(P_DATA), 32'(8'h3C));
        // bad stop bit, then a clean frame clears the flag
        send_frame(8'h81, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(3);
        chk("stp_err_set", 32'(stp_err), 32'(1));
        chk("par_err_after_stp", 32'(par_err), 32'(0));
        chk("p_data_held_stp", 32'(P_DATA), 32'(8'h3C));
        send_frame(8'h55, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(3);
        chk("stp_err_cleared", 32'(stp_err), 32'(0));
        // back-to-back frames with a one-cycle gap
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(1);
        send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(1);
        send_frame(8'h9A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(1);
        send_frame(8'hBC, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40);
        idle(5);
        check_reset_outputs("after_rst");
        // start glitch
        glitch(8);
        idle(5);
        chk("glitch_errs", 32'({par_err, stp_err}), 32'(0));
        chk("glitch_idle_samp_en", 32'(data_samp_en), 32'(0));
        chk("glitch_idle_edge_cnt", 32'(edge_cnt), 32'(0));
`ifdef UART_RX_START_CHECK_EN
        chk("glitch_p_data", 32'(P_DATA), 32'(0));
`else
        chk("glitch_p_data", 32'(P_DATA), 32'(8'hFF));
`endif
        idle(3);
        chk("scoreboard_drained", 32'(q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
